memref_wr_trace_cmp: RTL
========================

// Module: memref_wr_trace_cmp
// PURPOSE
//   Consumes the memref write-port streams (en/addr/data) of two jacobi_2d implementations (HIR and HLS) driven from one tstart.
//   Buffers each stream in its own FIFO, compares the two streams entry-by-entry in issue order, and reports a verdict.
//   Sits directly downstream of the kernel write ports, in parallel with memref_wr; it never drives memory.
// PARAMETERS
//   ADDR_W        10    memref write-address width
//   DATA_W        32    memref write-data width
//   FIFO_DEPTH    16    entries per stream FIFO; power of two, >=2
//   IDLE_TIMEOUT  1024  consecutive write-free cycles in RUN before the run is declared finished
//   CNT_W         16    width of all counters, saturating
// PORTS
//   clk             in   1       clock, rising edge
//   rst             in   1       asynchronous, active-low reset (0 = reset)
//   start           in   1       single-cycle pulse, same net as the kernels' tstart
//   a_wr_en         in   1       stream A (HIR) write enable
//   a_wr_addr       in   ADDR_W  stream A write address
//   a_wr_data       in   DATA_W  stream A write data
//   b_wr_en         in   1       stream B (HLS) write enable
//   b_wr_addr       in   ADDR_W  stream B write address
//   b_wr_data       in   DATA_W  stream B write data
//   busy            out  1       1 in RUN and DRAIN
//   done            out  1       1 in DONE, held until next start or reset
//   pass            out  1       valid while done=1
//   a_cnt, b_cnt    out  CNT_W   writes captured per stream
//   mismatch_cnt    out  CNT_W   compared pairs differing in addr or data
//   first_bad_addr  out  ADDR_W  stream A addr of the first mismatching pair
//   overflow        out  1       sticky: a push was dropped because its FIFO was full
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; FIFOs empty; idle counter 0.
//   FSM:
//     IDLE  -> RUN on start; clears counters, overflow, first_bad_addr and FIFOs.
//     RUN   -> DRAIN when the idle counter reaches IDLE_TIMEOUT; the counter clears on any a/b write.
//     DRAIN -> DONE in the cycle after at least one FIFO is empty (no further pairs can form).
//     DONE  -> RUN on start, with the same clears as from IDLE.
//   start in RUN or DRAIN is ignored.
//   Capture: in RUN, a_wr_en=1 at edge N pushes {a_wr_addr,a_wr_data} into FIFO A and increments a_cnt. B is symmetric.
//     Enables outside RUN are ignored and not counted.
//   Compare:
//     - When both FIFOs are non-empty, one pair is popped per cycle and compared.
//     - Earliest compare for a pair pushed at edge N is edge N+1; mismatch_cnt updates at that edge.
//     - first_bad_addr latches only on the mismatch that takes mismatch_cnt from 0 to 1.
//   Full FIFO: a push with pop in the same cycle is accepted. A push at full with no pop is dropped, sets overflow and still counts.
//   Simultaneous A and B pushes are independent.
//   Counters saturate at 2^CNT_W-1 and never wrap. FIFO pointers wrap modulo FIFO_DEPTH.
//   pass = (mismatch_cnt==0) && (a_cnt==b_cnt) && !overflow. Entries left unpaired at DONE imply a_cnt!=b_cnt, so pass=0.
//   Reset mid-operation: immediate return to the reset state, with no verdict.
// STRUCTURE
//   Package memref_trace_pkg:
//     - cmp_state_t enum {IDLE,RUN,DRAIN,DONE}
//     - trace_entry_t packed struct {addr[ADDR_W], data[DATA_W]}
//     - default widths
//   Sub-module trace_fifo: synchronous FIFO of trace_entry_t with DEPTH parameter, push/pop/full/empty, async active-low reset, clear input.
//   Instantiated twice.
//   Top holds the FSM, idle counter, comparator and saturating counters.
// TESTING
//   1. Identical 64-write streams, B delayed 3 cycles behind A -> done after last write + IDLE_TIMEOUT (+2 cycles); pass=1; a_cnt=b_cnt=64.
//   2. Same as 1 but B write #33 (addr 0x021) data 0xDEADBEEF -> mismatch_cnt=1; first_bad_addr=0x021; pass=0.
//   3. B lags A by 20 continuous writes with FIFO_DEPTH=16 -> overflow=1; pass=0; a_cnt=b_cnt.
//   4. A issues 10 writes, B issues 9 identical writes -> done; a_cnt=10; b_cnt=9; mismatch_cnt=0; pass=0.
//   5. rst=0 mid-RUN after 5 writes -> all outputs 0 within the reset cycle; state IDLE; later start gives a clean run with pass=1.
//   6. start pulsed in DONE after test 2 -> counters cleared; a rerun with identical streams gives pass=1.

Source files
------------

// File: rtl/memref_trace_pkg.sv
// Shared types and default widths for the memref write-trace comparator.
package memref_trace_pkg;

  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_FIFO_DEPTH   = 16;
  localparam int DEF_IDLE_TIMEOUT = 1024;
  localparam int DEF_CNT_W        = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } cmp_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous trace FIFO: pop data is combinational from the head, one-cycle push-to-visible latency.
// A push while full is accepted only if a pop happens in the same cycle; otherwise it is dropped.
module trace_fifo
  import memref_trace_pkg::*;
#(
  parameter int  DEPTH   = DEF_FIFO_DEPTH,
  parameter type entry_t = trace_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   push,
  input  entry_t push_dat,
  input  logic   pop,
  output entry_t pop_dat,
  output logic   full,
  output logic   empty
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign pop_dat = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/memref_wr_trace_cmp.sv
// Compares HIR and HLS memref write streams pair-by-pair in issue order; a pair compares one edge after both halves are queued.
// Never stalls the kernels: a push into a full FIFO with no pop is dropped and flagged via sticky overflow.
module memref_wr_trace_cmp
  import memref_trace_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              a_wr_en,
  input  logic [ADDR_W-1:0] a_wr_addr,
  input  logic [DATA_W-1:0] a_wr_data,
  input  logic              b_wr_en,
  input  logic [ADDR_W-1:0] b_wr_addr,
  input  logic [DATA_W-1:0] b_wr_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  a_cnt,
  output logic [CNT_W-1:0]  b_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [ADDR_W-1:0] first_bad_addr,
  output logic              overflow
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmp_entry_t;

  cmp_state_t    state;
  logic [IW-1:0] idle_cnt;
  cmp_entry_t    a_head, b_head;
  logic          a_full, a_empty, b_full, b_empty;
  logic          start_clr, a_push, b_push, cmp_vld, pair_bad, a_drop, b_drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign start_clr = start && (state == IDLE || state == DONE);
  assign a_push    = (state == RUN) && a_wr_en;
  assign b_push    = (state == RUN) && b_wr_en;
  assign cmp_vld   = (state == RUN || state == DRAIN) && !a_empty && !b_empty;
  assign pair_bad  = cmp_vld && (a_head != b_head);
  assign a_drop    = a_push && a_full && !cmp_vld;
  assign b_drop    = b_push && b_full && !cmp_vld;

  trace_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(cmp_entry_t)) u_fifo_a (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_clr),
    .push     (a_push),
    .push_dat ({a_wr_addr, a_wr_data}),
    .pop      (cmp_vld),
    .pop_dat  (a_head),
    .full     (a_full),
    .empty    (a_empty)
  );

  trace_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(cmp_entry_t)) u_fifo_b (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_clr),
    .push     (b_push),
    .push_dat ({b_wr_addr, b_wr_data}),
    .pop      (cmp_vld),
    .pop_dat  (b_head),
    .full     (b_full),
    .empty    (b_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            idle_cnt <= '0;
          end
        end
        RUN: begin
          // A write arriving as the timeout expires keeps the run alive.
          if (a_wr_en || b_wr_en) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IW'(IDLE_TIMEOUT)) begin
            state <= DRAIN;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (a_empty || b_empty) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_cnt          <= '0;
      b_cnt          <= '0;
      mismatch_cnt   <= '0;
      first_bad_addr <= '0;
      overflow       <= 1'b0;
    end else if (start_clr) begin
      a_cnt          <= '0;
      b_cnt          <= '0;
      mismatch_cnt   <= '0;
      first_bad_addr <= '0;
      overflow       <= 1'b0;
    end else begin
      if (a_push) a_cnt <= sat_inc(a_cnt);
      if (b_push) b_cnt <= sat_inc(b_cnt);
      if (pair_bad) begin
        mismatch_cnt <= sat_inc(mismatch_cnt);
        if (mismatch_cnt == '0) first_bad_addr <= a_head.addr;
      end
      if (a_drop || b_drop) overflow <= 1'b1;
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (mismatch_cnt == '0) && (a_cnt == b_cnt) && !overflow;

endmodule
